// File: rtl/shake_word_unpacker.sv
// Splits IN_WIDTH-bit SHAKE128 squeeze blocks into OUT_WIDTH-bit words, lowest bits first.
// Optional word limit with o_done is built when UNPACKER_WORD_LIMIT_EN is defined.
`ifndef SHAKE128_OUTPUT_SIZE
`define SHAKE128_OUTPUT_SIZE 1344
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module variable_shift #(
   parameter int WIDTH       = 8,
   parameter int SHIFT_WIDTH = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0]       i_vector,
   input  logic [SHIFT_WIDTH-1:0] i_shift,
   output logic [WIDTH-1:0]       o_vector
);
   assign o_vector = i_vector << i_shift;
endmodule

module shake_word_unpacker #(
   parameter int IN_WIDTH  = `SHAKE128_OUTPUT_SIZE,
   parameter int OUT_WIDTH = `WORD_SIZE,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_flush,
   input  logic [CNT_WIDTH-1:0] i_num_words,
   input  logic [IN_WIDTH-1:0]  i_data,
   input  logic                 i_data_valid,
   output logic                 o_data_ready,
   output logic [OUT_WIDTH-1:0] o_word,
   output logic                 o_word_valid,
   input  logic                 i_word_ready,
   output logic                 o_done
);
   localparam int BUF_W = IN_WIDTH + OUT_WIDTH;
   localparam int CW    = $clog2(BUF_W);
   localparam logic [CW-1:0] IN_W_C  = CW'(IN_WIDTH);
   localparam logic [CW-1:0] OUT_W_C = CW'(OUT_WIDTH);

   typedef enum logic [1:0] {S_FILL, S_DRAIN, S_DONE} state_t;

   logic [BUF_W-1:0] buffer;
   logic [BUF_W-1:0] buffer_nxt;
   logic [BUF_W-1:0] shifted;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_nxt;
   logic             word_inc;
   logic             done;
   state_t           state;

   // New block lands directly above the leftover bits so words can straddle blocks.
   variable_shift #(
      .WIDTH       (BUF_W),
      .SHIFT_WIDTH (CW)
   ) u_shift (
      .i_vector ({{OUT_WIDTH{1'b0}}, i_data}),
      .i_shift  (cnt),
      .o_vector (shifted)
   );

   always_comb begin
      if (done)
         state = S_DONE;
      else if (cnt >= OUT_W_C)
         state = S_DRAIN;
      else
         state = S_FILL;
   end

   always_comb begin
      buffer_nxt = buffer;
      cnt_nxt    = cnt;
      word_inc   = 1'b0;
      unique case (state)
         S_FILL: begin
            if (i_data_valid) begin
               buffer_nxt = buffer | shifted;
               cnt_nxt    = cnt + IN_W_C;
            end
         end
         S_DRAIN: begin
            if (i_word_ready) begin
               buffer_nxt = buffer >> OUT_WIDTH;
               cnt_nxt    = cnt - OUT_W_C;
               word_inc   = 1'b1;
            end
         end
         default: begin
         end
      endcase
      if (i_flush) begin
         buffer_nxt = '0;
         cnt_nxt    = '0;
         word_inc   = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         buffer <= '0;
         cnt    <= '0;
      end else begin
         buffer <= buffer_nxt;
         cnt    <= cnt_nxt;
      end
   end

`ifdef UNPACKER_WORD_LIMIT_EN
   logic [CNT_WIDTH-1:0] word_cnt;
   logic [CNT_WIDTH-1:0] limit;
   logic [CNT_WIDTH-1:0] word_cnt_inc;

   assign word_cnt_inc = word_cnt + CNT_WIDTH'(1);

   // A zero limit never matches, so the stream runs unbounded.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         word_cnt <= '0;
         limit    <= '0;
         done     <= 1'b0;
      end else if (i_flush) begin
         word_cnt <= '0;
         limit    <= i_num_words;
         done     <= 1'b0;
      end else if (word_inc) begin
         word_cnt <= word_cnt_inc;
         if ((limit != '0) && (word_cnt_inc == limit))
            done <= 1'b1;
      end
   end
`else
   logic unused_sig;
   assign done       = 1'b0;
   assign unused_sig = ^{i_num_words, word_inc};
`endif

   assign o_data_ready = (state == S_FILL);
   assign o_word_valid = (state == S_DRAIN);
   assign o_word       = buffer[OUT_WIDTH-1:0];
   assign o_done       = done;

endmodule
